// File: rtl/id_ex_stage_pkg.sv
// Shared ALU definitions: ALUOP classes, R-type funct codes, ALU control codes
// and the ID/EX control bundle. Guarded so the ALU can pull it in as well.
`ifndef ID_EX_STAGE_PKG_SV
`define ID_EX_STAGE_PKG_SV
package id_ex_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALUCTL_AND     = 4'b0000;
  localparam logic [3:0] ALUCTL_ADD     = 4'b0010;
  localparam logic [3:0] ALUCTL_OR      = 4'b0011;
  localparam logic [3:0] ALUCTL_SLT     = 4'b0100;
  localparam logic [3:0] ALUCTL_SUB     = 4'b0110;
  localparam logic [3:0] ALUCTL_INVALID = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       valid;
  } ex_ctrl_t;

  // A bubble still carries an ADD code so the ALU sees a harmless operation.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    alu_ctl:  ALUCTL_ADD,
    alusrc:   1'b0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    valid:    1'b0
  };

endpackage
`endif

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALU control decode: main-decoder ALU class plus R-type funct
// field to the 4-bit ALU operation code.
module alu_control (
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o
);
  import id_ex_stage_pkg::*;

  always_comb begin
    alu_ctl_o = ALUCTL_INVALID;
    case (aluop_i)
      ALUOP_ADD: alu_ctl_o = ALUCTL_ADD;
      ALUOP_SUB: alu_ctl_o = ALUCTL_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_ctl_o = ALUCTL_ADD;
          FUNCT_SUB: alu_ctl_o = ALUCTL_SUB;
          FUNCT_AND: alu_ctl_o = ALUCTL_AND;
          FUNCT_OR:  alu_ctl_o = ALUCTL_OR;
          FUNCT_SLT: alu_ctl_o = ALUCTL_SLT;
          default:   alu_ctl_o = ALUCTL_INVALID;
        endcase
      end
      default: alu_ctl_o = ALUCTL_INVALID;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding from
// EX/MEM and MEM/WB, and load-use hazard detection toward the decode stage.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] ID_RS_DATA,
  input  logic [WIDTH-1:0] ID_RT_DATA,
  input  logic [15:0]      ID_IMM,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic [4:0]       ID_RD,
  input  logic [1:0]       ID_ALUOP,
  input  logic [5:0]       ID_FUNCT,
  input  logic             ID_ALUSRC,
  input  logic             ID_REGDST,
  input  logic             ID_REGWRITE,
  input  logic             ID_MEMREAD,
  input  logic             ID_MEMWRITE,
  input  logic             ID_MEMTOREG,
  input  logic             ID_VALID,
  input  logic             MEM_REGWRITE,
  input  logic [4:0]       MEM_RD,
  input  logic [WIDTH-1:0] MEM_RESULT,
  input  logic             WB_REGWRITE,
  input  logic [4:0]       WB_RD,
  input  logic [WIDTH-1:0] WB_RESULT,
  output logic [WIDTH-1:0] EX_IN1,
  output logic [WIDTH-1:0] EX_IN2,
  output logic [3:0]       EX_CONTROL,
  output logic [WIDTH-1:0] EX_STORE_DATA,
  output logic [4:0]       EX_WDEST,
  output logic             EX_REGWRITE,
  output logic             EX_MEMREAD,
  output logic             EX_MEMWRITE,
  output logic             EX_MEMTOREG,
  output logic             EX_VALID,
  output logic             HAZARD
);
  import id_ex_stage_pkg::*;

  logic [WIDTH-1:0] rs_data_q, rs_data_d;
  logic [WIDTH-1:0] rt_data_q, rt_data_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic [4:0]       wdest_q, wdest_d;
  ex_ctrl_t         ctrl_q, ctrl_d;

  logic [3:0]       id_alu_ctl;
  logic [WIDTH-1:0] id_imm_ext;

  alu_control u_alu_control (
    .aluop_i   (ID_ALUOP),
    .funct_i   (ID_FUNCT),
    .alu_ctl_o (id_alu_ctl)
  );

  assign id_imm_ext = {{(WIDTH-16){ID_IMM[15]}}, ID_IMM};

  always_comb begin
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    wdest_d   = wdest_q;
    ctrl_d    = ctrl_q;
    if (FLUSH) begin
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      wdest_d   = '0;
      ctrl_d    = EX_CTRL_BUBBLE;
    end else if (!STALL) begin
      rs_data_d       = ID_RS_DATA;
      rt_data_d       = ID_RT_DATA;
      imm_d           = id_imm_ext;
      rs_d            = ID_RS;
      rt_d            = ID_RT;
      wdest_d         = ID_REGDST ? ID_RD : ID_RT;
      ctrl_d.alu_ctl  = id_alu_ctl;
      ctrl_d.alusrc   = ID_ALUSRC;
      ctrl_d.regwrite = ID_REGWRITE;
      ctrl_d.memread  = ID_MEMREAD;
      ctrl_d.memwrite = ID_MEMWRITE;
      ctrl_d.memtoreg = ID_MEMTOREG;
      ctrl_d.valid    = ID_VALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wdest_q   <= '0;
      ctrl_q    <= EX_CTRL_BUBBLE;
    end else begin
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      wdest_q   <= wdest_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Register 0 is hardwired to zero, so a write targeting it is never forwarded.
  logic rs_mem_hit, rs_wb_hit, rt_mem_hit, rt_wb_hit;
  logic [WIDTH-1:0] rs_fwd, rt_fwd;

  assign rs_mem_hit = MEM_REGWRITE && (MEM_RD != 5'd0) && (MEM_RD == rs_q);
  assign rs_wb_hit  = WB_REGWRITE  && (WB_RD  != 5'd0) && (WB_RD  == rs_q);
  assign rt_mem_hit = MEM_REGWRITE && (MEM_RD != 5'd0) && (MEM_RD == rt_q);
  assign rt_wb_hit  = WB_REGWRITE  && (WB_RD  != 5'd0) && (WB_RD  == rt_q);

  assign rs_fwd = rs_mem_hit ? MEM_RESULT : (rs_wb_hit ? WB_RESULT : rs_data_q);
  assign rt_fwd = rt_mem_hit ? MEM_RESULT : (rt_wb_hit ? WB_RESULT : rt_data_q);

  assign EX_IN1        = rs_fwd;
  assign EX_IN2        = ctrl_q.alusrc ? imm_q : rt_fwd;
  assign EX_STORE_DATA = rt_fwd;
  assign EX_CONTROL    = ctrl_q.alu_ctl;
  assign EX_WDEST      = wdest_q;
  assign EX_REGWRITE   = ctrl_q.regwrite & ctrl_q.valid;
  assign EX_MEMREAD    = ctrl_q.memread  & ctrl_q.valid;
  assign EX_MEMWRITE   = ctrl_q.memwrite & ctrl_q.valid;
  assign EX_MEMTOREG   = ctrl_q.memtoreg;
  assign EX_VALID      = ctrl_q.valid;

  // Load result is not available until after MEM; upstream must stall on this.
  assign HAZARD = EX_MEMREAD && (rt_q != 5'd0) && ((rt_q == ID_RS) || (rt_q == ID_RT));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH;
  logic [31:0] ID_RS_DATA, ID_RT_DATA;
  logic [15:0] ID_IMM;
  logic [4:0]  ID_RS, ID_RT, ID_RD;
  logic [1:0]  ID_ALUOP;
  logic [5:0]  ID_FUNCT;
  logic        ID_ALUSRC, ID_REGDST, ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG, ID_VALID;
  logic        MEM_REGWRITE, WB_REGWRITE;
  logic [4:0]  MEM_RD, WB_RD;
  logic [31:0] MEM_RESULT, WB_RESULT;
  logic [31:0] EX_IN1, EX_IN2, EX_STORE_DATA;
  logic [3:0]  EX_CONTROL;
  logic [4:0]  EX_WDEST;
  logic        EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG, EX_VALID, HAZARD;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  id_ex_stage #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .ID_RS_DATA(ID_RS_DATA), .ID_RT_DATA(ID_RT_DATA), .ID_IMM(ID_IMM),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RD(ID_RD),
    .ID_ALUOP(ID_ALUOP), .ID_FUNCT(ID_FUNCT),
    .ID_ALUSRC(ID_ALUSRC), .ID_REGDST(ID_REGDST), .ID_REGWRITE(ID_REGWRITE),
    .ID_MEMREAD(ID_MEMREAD), .ID_MEMWRITE(ID_MEMWRITE), .ID_MEMTOREG(ID_MEMTOREG),
    .ID_VALID(ID_VALID),
    .MEM_REGWRITE(MEM_REGWRITE), .MEM_RD(MEM_RD), .MEM_RESULT(MEM_RESULT),
    .WB_REGWRITE(WB_REGWRITE), .WB_RD(WB_RD), .WB_RESULT(WB_RESULT),
    .EX_IN1(EX_IN1), .EX_IN2(EX_IN2), .EX_CONTROL(EX_CONTROL),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_WDEST(EX_WDEST),
    .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE),
    .EX_MEMTOREG(EX_MEMTOREG), .EX_VALID(EX_VALID), .HAZARD(HAZARD)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently held in EX, as plain values.
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [3:0]  m_code;
  logic        m_alusrc, m_regw, m_memr, m_memw, m_m2r, m_valid;

  function automatic logic [3:0] op_code(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'd0) return 4'd2;
    if (aluop == 2'd1) return 4'd6;
    if (aluop == 2'd3) return 4'd15;
    case (funct)
      6'd32:   return 4'd2;   // add
      6'd34:   return 4'd6;   // sub
      6'd36:   return 4'd0;   // and
      6'd37:   return 4'd3;   // or
      6'd42:   return 4'd4;   // slt
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] own);
    if (r == 0) return own;
    if (MEM_REGWRITE && MEM_RD == r) return MEM_RESULT;
    if (WB_REGWRITE && WB_RD == r) return WB_RESULT;
    return own;
  endfunction

  task automatic model_bubble();
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_dest = 0;
    m_code = 4'd2; m_alusrc = 0; m_regw = 0; m_memr = 0; m_memw = 0; m_m2r = 0; m_valid = 0;
  endtask

  always @(posedge CLK) begin
    if (RESET || FLUSH) model_bubble();
    else if (!STALL) begin
      m_rsd = ID_RS_DATA; m_rtd = ID_RT_DATA;
      m_imm = ID_IMM[15] ? 32'hFFFF_0000 + 32'(ID_IMM) : 32'(ID_IMM);
      m_rs = ID_RS; m_rt = ID_RT; m_dest = ID_REGDST ? ID_RD : ID_RT;
      m_code = op_code(ID_ALUOP, ID_FUNCT);
      m_alusrc = ID_ALUSRC; m_regw = ID_REGWRITE; m_memr = ID_MEMREAD;
      m_memw = ID_MEMWRITE; m_m2r = ID_MEMTOREG; m_valid = ID_VALID;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      logic [31:0] e_rt;
      e_rt = fwd(m_rt, m_rtd);
      check("ex_in1", EX_IN1, fwd(m_rs, m_rsd));
      check("ex_in2", EX_IN2, m_alusrc ? m_imm : e_rt);
      check("ex_store_data", EX_STORE_DATA, e_rt);
      check("ex_control", 32'(EX_CONTROL), 32'(m_code));
      check("ex_wdest", 32'(EX_WDEST), 32'(m_dest));
      check("ex_regwrite", 32'(EX_REGWRITE), 32'(m_valid && m_regw));
      check("ex_memread", 32'(EX_MEMREAD), 32'(m_valid && m_memr));
      check("ex_memwrite", 32'(EX_MEMWRITE), 32'(m_valid && m_memw));
      check("ex_memtoreg", 32'(EX_MEMTOREG), 32'(m_m2r));
      check("ex_valid", 32'(EX_VALID), 32'(m_valid));
      check("hazard", 32'(HAZARD),
            32'(m_valid && m_memr && m_rt != 0 && (m_rt == ID_RS || m_rt == ID_RT)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ctl = {alusrc, regdst, regwrite, memread, memwrite, memtoreg, valid}
  task automatic issue(input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [1:0] aluop, input logic [5:0] funct, input logic [6:0] ctl);
    ID_RS_DATA = rsd; ID_RT_DATA = rtd; ID_IMM = imm;
    ID_RS = rs; ID_RT = rt; ID_RD = rd; ID_ALUOP = aluop; ID_FUNCT = funct;
    {ID_ALUSRC, ID_REGDST, ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG, ID_VALID} = ctl;
  endtask

  task automatic clear_fwd();
    MEM_REGWRITE = 0; MEM_RD = 0; MEM_RESULT = 0;
    WB_REGWRITE = 0; WB_RD = 0; WB_RESULT = 0;
  endtask

  logic [1:0] t_op  [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
  logic [5:0] t_fn  [6] = '{6'b100101, 6'b101010, 6'b000000, 6'b000000, 6'b100000, 6'b101010};
  logic [3:0] t_exp [6] = '{4'b0011, 4'b0100, 4'b1111, 4'b0110, 4'b1111, 4'b0010};

  initial begin
    RESET = 1; STALL = 0; FLUSH = 0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 7'b0);
    clear_fwd();
    tick();
    tick();
    RESET = 0;
    cmp_en = 1;
    #1;
    check("reset_control", 32'(EX_CONTROL), 32'h2);
    check("reset_in1", EX_IN1, 32'h0);
    check("reset_valid", 32'(EX_VALID), 32'h0);
    check("reset_hazard", 32'(HAZARD), 32'h0);

    // R-type add
    issue(5, 7, 16'h0, 5'd1, 5'd2, 5'd4, 2'b10, 6'b100000, 7'b0110001);
    tick();
    check("add_in1", EX_IN1, 32'd5);
    check("add_in2", EX_IN2, 32'd7);
    check("add_control", 32'(EX_CONTROL), 32'h2);
    check("add_wdest", 32'(EX_WDEST), 32'd4);

    // lw r8, -4(r1) then a consumer of r8
    issue(100, 0, 16'hFFFC, 5'd1, 5'd8, 5'd0, 2'b00, 6'b0, 7'b1011011);
    tick();
    check("lw_in2", EX_IN2, 32'hFFFF_FFFC);
    check("lw_control", 32'(EX_CONTROL), 32'h2);
    check("lw_wdest", 32'(EX_WDEST), 32'd8);
    issue(1, 2, 16'h0, 5'd8, 5'd3, 5'd9, 2'b10, 6'b100000, 7'b0110001);
    #1 check("hazard_rs", 32'(HAZARD), 32'h1);
    ID_RS = 5'd9; ID_RT = 5'd8;
    #1 check("hazard_rt", 32'(HAZARD), 32'h1);
    ID_RT = 5'd3;
    #1 check("hazard_none", 32'(HAZARD), 32'h0);

    // forwarding priority
    issue(33, 55, 16'h0, 5'd3, 5'd5, 5'd6, 2'b10, 6'b100010, 7'b0110001);
    tick();
    MEM_REGWRITE = 1; MEM_RD = 3; MEM_RESULT = 100;
    WB_REGWRITE = 1; WB_RD = 3; WB_RESULT = 200;
    #1 check("fwd_mem_prio", EX_IN1, 32'd100);
    check("sub_control", 32'(EX_CONTROL), 32'h6);
    MEM_RD = 0;
    #1 check("fwd_wb_memrd0", EX_IN1, 32'd200);
    MEM_RD = 3; MEM_REGWRITE = 0;
    #1 check("fwd_wb_memoff", EX_IN1, 32'd200);
    WB_RD = 5;
    #1 check("fwd_none_rs", EX_IN1, 32'd33);
    check("fwd_wb_rt", EX_IN2, 32'd200);
    check("fwd_wb_store", EX_STORE_DATA, 32'd200);

    // register 0 never forwards
    issue(11, 22, 16'h0, 5'd0, 5'd0, 5'd7, 2'b10, 6'b100100, 7'b0110001);
    tick();
    MEM_REGWRITE = 1; MEM_RD = 0; MEM_RESULT = 9;
    WB_REGWRITE = 1; WB_RD = 0; WB_RESULT = 9;
    #1 check("r0_in1", EX_IN1, 32'd11);
    check("r0_in2", EX_IN2, 32'd22);
    check("and_control", 32'(EX_CONTROL), 32'h0);
    clear_fwd();

    for (int i = 0; i < 6; i++) begin
      issue(32'(i), 32'(i + 1), 16'h1234, 5'd1, 5'd2, 5'd3, t_op[i], t_fn[i], 7'b0110001);
      tick();
      check("decode_table", 32'(EX_CONTROL), 32'(t_exp[i]));
    end

    // positive immediate, and control gating by VALID
    issue(0, 0, 16'h1234, 5'd1, 5'd2, 5'd3, 2'b00, 6'b0, 7'b1010100);
    tick();
    check("imm_pos", EX_IN2, 32'h0000_1234);
    check("gate_regwrite", 32'(EX_REGWRITE), 32'h0);
    check("gate_memwrite", 32'(EX_MEMWRITE), 32'h0);

    // stall holds, flush wins over stall
    issue(32'hAAA, 32'h111, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100101, 7'b0110001);
    tick();
    STALL = 1;
    issue(32'hBBB, 32'h222, 16'h5, 5'd4, 5'd5, 5'd6, 2'b10, 6'b101010, 7'b0110001);
    tick();
    check("stall1_in1", EX_IN1, 32'hAAA);
    issue(32'hCCC, 32'h333, 16'h6, 5'd7, 5'd8, 5'd9, 2'b01, 6'b0, 7'b1011011);
    tick();
    check("stall2_in1", EX_IN1, 32'hAAA);
    check("stall2_control", 32'(EX_CONTROL), 32'h3);
    check("stall2_wdest", 32'(EX_WDEST), 32'd3);
    FLUSH = 1;
    tick();
    check("flush_valid", 32'(EX_VALID), 32'h0);
    check("flush_control", 32'(EX_CONTROL), 32'h2);
    check("flush_in1", EX_IN1, 32'h0);
    FLUSH = 0; STALL = 0;

    // reset mid-stream dominates stall
    issue(32'h77, 0, 16'h8, 5'd1, 5'd10, 5'd0, 2'b00, 6'b0, 7'b1011011);
    tick();
    issue(1, 2, 16'h0, 5'd10, 5'd3, 5'd4, 2'b10, 6'b100000, 7'b0110001);
    #1 check("pre_reset_hazard", 32'(HAZARD), 32'h1);
    RESET = 1; STALL = 1;
    tick();
    check("rst_valid", 32'(EX_VALID), 32'h0);
    check("rst_hazard", 32'(HAZARD), 32'h0);
    check("rst_control", 32'(EX_CONTROL), 32'h2);
    check("rst_in1", EX_IN1, 32'h0);
    RESET = 0; STALL = 0;
    tick();
    check("post_reset_in1", EX_IN1, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
